// File: rtl/axi_r_pkg.sv
// Shared types and constants for the AXI read-data return path.
// Holds the grant FSM encoding, master tags and round-robin helper.
package axi_r_pkg;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  localparam logic [3:0] TAG_M0 = 4'h0;
  localparam logic [3:0] TAG_M1 = 4'h1;

  localparam int NUM_RSLAVES = 3;

  // Successor in the slave ring 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/r_master_port.sv
// One master's return port: burst-locked round-robin grant over three slaves.
// Ports: clk_i/rst_i, per-slave tag/rid/data/resp/last/valid in,
// rready_m_i from master, rready_s_o to slaves, routed R channel out.
module r_master_port
  import axi_r_pkg::*;
#(
  parameter int MIDX   = 0,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             tag_i   [NUM_RSLAVES],
  input  logic [ID_W-1:0]        rid_i   [NUM_RSLAVES],
  input  logic [DATA_W-1:0]      rdata_i [NUM_RSLAVES],
  input  logic [1:0]             rresp_i [NUM_RSLAVES],
  input  logic [NUM_RSLAVES-1:0] rlast_i,
  input  logic [NUM_RSLAVES-1:0] rvalid_i,
  input  logic                   rready_m_i,
  output logic [NUM_RSLAVES-1:0] rready_s_o,
  output logic [ID_W-1:0]        rid_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [1:0]             rresp_o,
  output logic                   rlast_o,
  output logic                   rvalid_o
);

  r_state_e state_q, state_d;
  logic [1:0] g_q, g_d;
  logic [1:0] p_q, p_d;
  logic [NUM_RSLAVES-1:0] hit, req;
  logic [1:0] pick, cand;
  logic found, done;

  always_comb begin
    for (int k = 0; k < NUM_RSLAVES; k++) begin
      hit[k] = (tag_i[k] == MIDX[3:0]);
    end
  end

  assign req = rvalid_i & hit;

  // Scan p, p+1, p+2 (mod 3) and take the first requester.
  always_comb begin
    pick  = p_q;
    found = 1'b0;
    cand  = p_q;
    for (int i = 0; i < NUM_RSLAVES; i++) begin
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= R_IDLE;
      g_q     <= 2'd0;
      p_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
    end
  end

  assign done = rvalid_o & rready_m_i & rlast_o;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    unique case (state_q)
      R_IDLE: begin
        if (|req) begin
          state_d = R_BURST;
          g_d     = pick;
        end
      end
      R_BURST: begin
        if (done) begin
          state_d = R_IDLE;
          p_d     = rr_next(g_q);
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rready_s_o = '0;
    rid_o      = '0;
    rdata_o    = '0;
    rresp_o    = '0;
    rlast_o    = 1'b0;
    rvalid_o   = 1'b0;
    if (state_q == R_BURST) begin
      rvalid_o        = rvalid_i[g_q] & hit[g_q];
      rready_s_o[g_q] = rready_m_i;
      rid_o           = rid_i[g_q];
      rdata_o         = rdata_i[g_q];
      rresp_o         = rresp_i[g_q];
      rlast_o         = rlast_i[g_q];
    end
  end

endmodule

// File: rtl/read_data_router.sv
// AXI R-channel return router: three slaves (ROM/IM/DM) to two masters.
// Ports: ACLK/ARESET, R channels of S0..S2 in, M0/M1 out, bad_tag_err.
module read_data_router
  import axi_r_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDS_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [IDS_W-1:0]  RID_S0,
  input  logic [DATA_W-1:0] RDATA_S0,
  input  logic [1:0]        RRESP_S0,
  input  logic              RLAST_S0,
  input  logic              RVALID_S0,
  output logic              RREADY_S0,
  input  logic [IDS_W-1:0]  RID_S1,
  input  logic [DATA_W-1:0] RDATA_S1,
  input  logic [1:0]        RRESP_S1,
  input  logic              RLAST_S1,
  input  logic              RVALID_S1,
  output logic              RREADY_S1,
  input  logic [IDS_W-1:0]  RID_S2,
  input  logic [DATA_W-1:0] RDATA_S2,
  input  logic [1:0]        RRESP_S2,
  input  logic              RLAST_S2,
  input  logic              RVALID_S2,
  output logic              RREADY_S2,
  output logic [ID_W-1:0]   RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  output logic [ID_W-1:0]   RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1,
  output logic              bad_tag_err
);

  logic [3:0]             tag    [NUM_RSLAVES];
  logic [ID_W-1:0]        rid_lo [NUM_RSLAVES];
  logic [DATA_W-1:0]      rdata  [NUM_RSLAVES];
  logic [1:0]             rresp  [NUM_RSLAVES];
  logic [NUM_RSLAVES-1:0] rlast, rvalid, drain, rr0, rr1;
  logic bad_q, bad_d;

  assign tag[0]    = RID_S0[IDS_W-1 -: 4];
  assign tag[1]    = RID_S1[IDS_W-1 -: 4];
  assign tag[2]    = RID_S2[IDS_W-1 -: 4];
  assign rid_lo[0] = RID_S0[ID_W-1:0];
  assign rid_lo[1] = RID_S1[ID_W-1:0];
  assign rid_lo[2] = RID_S2[ID_W-1:0];
  assign rdata[0]  = RDATA_S0;
  assign rdata[1]  = RDATA_S1;
  assign rdata[2]  = RDATA_S2;
  assign rresp[0]  = RRESP_S0;
  assign rresp[1]  = RRESP_S1;
  assign rresp[2]  = RRESP_S2;
  assign rlast     = {RLAST_S2, RLAST_S1, RLAST_S0};
  assign rvalid    = {RVALID_S2, RVALID_S1, RVALID_S0};

  // Beats whose tag names neither master are swallowed in place.
  always_comb begin
    for (int k = 0; k < NUM_RSLAVES; k++) begin
      drain[k] = rvalid[k] & (tag[k] != TAG_M0) & (tag[k] != TAG_M1);
    end
  end

  r_master_port #(
    .MIDX(0), .DATA_W(DATA_W), .ID_W(ID_W)
  ) u_m0 (
    .clk_i(ACLK), .rst_i(ARESET),
    .tag_i(tag), .rid_i(rid_lo), .rdata_i(rdata),
    .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid),
    .rready_m_i(RREADY_M0), .rready_s_o(rr0),
    .rid_o(RID_M0), .rdata_o(RDATA_M0), .rresp_o(RRESP_M0),
    .rlast_o(RLAST_M0), .rvalid_o(RVALID_M0)
  );

  r_master_port #(
    .MIDX(1), .DATA_W(DATA_W), .ID_W(ID_W)
  ) u_m1 (
    .clk_i(ACLK), .rst_i(ARESET),
    .tag_i(tag), .rid_i(rid_lo), .rdata_i(rdata),
    .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid),
    .rready_m_i(RREADY_M1), .rready_s_o(rr1),
    .rid_o(RID_M1), .rdata_o(RDATA_M1), .rresp_o(RRESP_M1),
    .rlast_o(RLAST_M1), .rvalid_o(RVALID_M1)
  );

  assign RREADY_S0 = rr0[0] | rr1[0] | drain[0];
  assign RREADY_S1 = rr0[1] | rr1[1] | drain[1];
  assign RREADY_S2 = rr0[2] | rr1[2] | drain[2];

  assign bad_d = bad_q | (|drain);

  always_ff @(posedge ACLK) begin
    if (ARESET) bad_q <= 1'b0;
    else        bad_q <= bad_d;
  end

  assign bad_tag_err = bad_q;

endmodule

// File: tb/tb_read_data_router.sv
// Bench for read_data_router: directed scenarios plus random bursts.
// Beat-level scoreboard checks routing, atomicity and drain behaviour.
module tb_read_data_router;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  rid_s    [3];
  logic [31:0] rdata_s  [3];
  logic [1:0]  rresp_s  [3];
  logic        rlast_s  [3];
  logic        rvalid_s [3];
  logic        rready_s [3];
  logic [3:0]  rid_m    [2];
  logic [31:0] rdata_m  [2];
  logic [1:0]  rresp_m  [2];
  logic        rlast_m  [2];
  logic        rvalid_m [2];
  logic        rready_m [2];
  logic        bad_tag_err;

  always #5 ACLK = ~ACLK;

  read_data_router dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .RID_S0(rid_s[0]), .RDATA_S0(rdata_s[0]), .RRESP_S0(rresp_s[0]),
    .RLAST_S0(rlast_s[0]), .RVALID_S0(rvalid_s[0]), .RREADY_S0(rready_s[0]),
    .RID_S1(rid_s[1]), .RDATA_S1(rdata_s[1]), .RRESP_S1(rresp_s[1]),
    .RLAST_S1(rlast_s[1]), .RVALID_S1(rvalid_s[1]), .RREADY_S1(rready_s[1]),
    .RID_S2(rid_s[2]), .RDATA_S2(rdata_s[2]), .RRESP_S2(rresp_s[2]),
    .RLAST_S2(rlast_s[2]), .RVALID_S2(rvalid_s[2]), .RREADY_S2(rready_s[2]),
    .RID_M0(rid_m[0]), .RDATA_M0(rdata_m[0]), .RRESP_M0(rresp_m[0]),
    .RLAST_M0(rlast_m[0]), .RVALID_M0(rvalid_m[0]), .RREADY_M0(rready_m[0]),
    .RID_M1(rid_m[1]), .RDATA_M1(rdata_m[1]), .RRESP_M1(rresp_m[1]),
    .RLAST_M1(rlast_m[1]), .RVALID_M1(rvalid_m[1]), .RREADY_M1(rready_m[1]),
    .bad_tag_err(bad_tag_err)
  );

  beat_t sq [3][$];
  bit    gap [3];
  int    owner [2];
  int    log_src [2][$];
  int    rcv [2];
  bit    exp_bad;
  int    total = 0;
  int    bad = 0;
  int    serial = 0;

  task automatic chk(string t, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic load(int k, logic [7:0] id, logic [31:0] base, int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.id   = id;
      b.data = base + 32'(i);
      b.resp = 2'(i);
      b.last = (i == n - 1);
      sq[k].push_back(b);
    end
  endtask

  // Present queue heads, then settle to the falling edge.
  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      if (sq[k].size() > 0) begin
        rid_s[k]    = sq[k][0].id;
        rdata_s[k]  = sq[k][0].data;
        rresp_s[k]  = sq[k][0].resp;
        rlast_s[k]  = sq[k][0].last;
        rvalid_s[k] = !gap[k];
      end else begin
        rid_s[k]    = '0;
        rdata_s[k]  = '0;
        rresp_s[k]  = '0;
        rlast_s[k]  = 1'b0;
        rvalid_s[k] = 1'b0;
      end
    end
    @(negedge ACLK);
  endtask

  // Scoreboard: every master-side handshake must be the head beat of
  // the slave owning that master's burst; every legal slave-side
  // handshake must show up at its master; illegal ones vanish.
  task automatic model();
    bit    matched [3];
    bit    pop [3];
    bit    set_bad;
    int    src;
    beat_t b;
    set_bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      matched[k] = 1'b0;
      pop[k]     = 1'b0;
    end
    chk("bad_tag_err", bad_tag_err, exp_bad);
    for (int m = 0; m < 2; m++) begin
      if (rvalid_m[m] && rready_m[m]) begin
        src = -1;
        if (owner[m] >= 0) src = owner[m];
        else begin
          for (int k = 0; k < 3; k++) begin
            if (src < 0 && rvalid_s[k] && sq[k].size() > 0 &&
                sq[k][0].id[7:4] == 4'(m) &&
                sq[k][0].data == rdata_m[m]) src = k;
          end
        end
        chk("route_src_found", src >= 0, 1);
        if (src >= 0) begin
          chk("src_valid", rvalid_s[src] && sq[src].size() > 0, 1);
          if (sq[src].size() > 0) begin
            b = sq[src][0];
            chk("rid_m", rid_m[m], b.id[3:0]);
            chk("rdata_m", rdata_m[m], b.data);
            chk("rresp_m", rresp_m[m], b.resp);
            chk("rlast_m", rlast_m[m], b.last);
            chk("src_rready", rready_s[src], 1);
            matched[src] = 1'b1;
            if (owner[m] < 0) log_src[m].push_back(src);
            owner[m] = b.last ? -1 : src;
            rcv[m]++;
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (rvalid_s[k] && rready_s[k] && sq[k].size() > 0) begin
        pop[k] = 1'b1;
        if (sq[k][0].id[7:4] > 4'd1) set_bad = 1'b1;
        else chk("beat_routed", matched[k], 1);
      end
    end
    @(posedge ACLK);
    #1;
    for (int k = 0; k < 3; k++) if (pop[k]) void'(sq[k].pop_front());
    if (set_bad) exp_bad = 1'b1;
  endtask

  task automatic tick();
    drive();
    model();
  endtask

  function automatic bit busy();
    return sq[0].size() > 0 || sq[1].size() > 0 ||
           sq[2].size() > 0 || owner[0] >= 0 || owner[1] >= 0;
  endfunction

  task automatic run_idle(string t, int bound);
    int c = 0;
    while (busy() && c < bound) begin
      tick();
      c++;
    end
    chk(t, c < bound, 1);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    for (int k = 0; k < 3; k++) sq[k].delete();
    owner[0] = -1;
    owner[1] = -1;
    exp_bad  = 1'b0;
  endtask

  int n0, e0, e1, len, tg, base1;
  logic [7:0] rid;

  initial begin
    ARESET = 1'b1;
    rready_m[0] = 1'b1;
    rready_m[1] = 1'b1;
    for (int k = 0; k < 3; k++) gap[k] = 1'b0;
    owner[0] = -1;
    owner[1] = -1;
    exp_bad = 1'b0;
    rcv[0] = 0;
    rcv[1] = 0;
    drive();
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    // Reset state
    drive();
    chk("rst_rvalid_m0", rvalid_m[0], 0);
    chk("rst_rvalid_m1", rvalid_m[1], 0);
    chk("rst_rready_s0", rready_s[0], 0);
    chk("rst_rready_s1", rready_s[1], 0);
    chk("rst_rready_s2", rready_s[2], 0);
    chk("rst_bad", bad_tag_err, 0);
    model();

    // Round robin: S0 then S2, then S0 again
    log_src[0].delete();
    load(0, 8'h01, 32'hB0, 2);
    load(2, 8'h02, 32'hC0, 2);
    run_idle("rr1_done", 40);
    load(0, 8'h04, 32'hD0, 2);
    load(2, 8'h05, 32'hE0, 2);
    run_idle("rr2_done", 40);
    chk("rr_count", log_src[0].size(), 4);
    if (log_src[0].size() == 4) begin
      chk("rr_first", log_src[0][0], 0);
      chk("rr_second", log_src[0][1], 2);
      chk("rr_third", log_src[0][2], 0);
      chk("rr_fourth", log_src[0][3], 2);
    end

    // Single 4-beat burst from S1 to M0
    load(1, 8'h03, 32'hA0, 4);
    for (int i = 0; i < 6; i++) begin
      drive();
      if (i == 0 || i == 5) begin
        chk("sb_rvalid_m0_off", rvalid_m[0], 0);
        chk("sb_rready_s1_off", rready_s[1], 0);
      end else begin
        chk("sb_rvalid_m0", rvalid_m[0], 1);
        chk("sb_rid_m0", rid_m[0], 4'h3);
        chk("sb_rdata_m0", rdata_m[0], 32'hA0 + 32'(i - 1));
        chk("sb_rlast_m0", rlast_m[0], i == 4);
        chk("sb_rvalid_m1", rvalid_m[1], 0);
      end
      model();
    end

    // Concurrent masters
    load(0, 8'h07, 32'hF0, 2);
    load(2, 8'h18, 32'h70, 2);
    drive();
    chk("cc_arb_m0", rvalid_m[0], 0);
    chk("cc_arb_m1", rvalid_m[1], 0);
    model();
    drive();
    chk("cc_rvalid_m0", rvalid_m[0], 1);
    chk("cc_rvalid_m1", rvalid_m[1], 1);
    chk("cc_rdata_m0", rdata_m[0], 32'hF0);
    chk("cc_rdata_m1", rdata_m[1], 32'h70);
    chk("cc_rid_m1", rid_m[1], 4'h8);
    model();
    run_idle("cc_done", 20);

    // Backpressure and slave gap on M1
    base1 = rcv[1];
    load(1, 8'h15, 32'h90, 4);
    for (int i = 0; i < 10; i++) begin
      rready_m[1] = !(i >= 2 && i <= 4);
      gap[1] = (i == 6 || i == 7);
      drive();
      if (i >= 1) chk("bp_rready_pass", rready_s[1], rready_m[1]);
      model();
    end
    rready_m[1] = 1'b1;
    gap[1] = 1'b0;
    run_idle("bp_done", 20);
    chk("bp_beats", rcv[1] - base1, 4);

    // Illegal tag is drained
    load(2, 8'h53, 32'h55, 1);
    drive();
    chk("il_rready_s2", rready_s[2], 1);
    chk("il_rvalid_m0", rvalid_m[0], 0);
    chk("il_rvalid_m1", rvalid_m[1], 0);
    model();
    repeat (3) tick();
    chk("il_sticky", bad_tag_err, 1);

    // Reset on beat 2 of a burst; S0 wins afterwards
    load(1, 8'h06, 32'h30, 4);
    tick();
    tick();
    do_reset();
    log_src[0].delete();
    load(0, 8'h01, 32'h40, 2);
    load(2, 8'h02, 32'h50, 2);
    drive();
    chk("rm_rvalid_m0", rvalid_m[0], 0);
    chk("rm_rvalid_m1", rvalid_m[1], 0);
    chk("rm_rready_s0", rready_s[0], 0);
    chk("rm_rready_s1", rready_s[1], 0);
    chk("rm_rready_s2", rready_s[2], 0);
    chk("rm_bad_clr", bad_tag_err, 0);
    model();
    run_idle("rm_done", 30);
    chk("rm_cnt", log_src[0].size(), 2);
    if (log_src[0].size() > 0) chk("rm_first_s0", log_src[0][0], 0);

    // Random traffic
    rcv[0] = 0;
    rcv[1] = 0;
    e0 = 0;
    e1 = 0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 15; j++) begin
        n0 = int'($urandom_range(0, 9));
        if (n0 < 5) tg = 0;
        else if (n0 < 9) tg = 1;
        else tg = int'($urandom_range(2, 15));
        len = int'($urandom_range(1, 4));
        rid = {4'(tg), 4'($urandom)};
        serial++;
        load(k, rid, {8'(k), 24'(serial * 16)}, len);
        if (tg == 0) e0 += len;
        else if (tg == 1) e1 += len;
      end
    end
    n0 = 0;
    while (busy() && n0 < 4000) begin
      rready_m[0] = ($urandom_range(0, 3) != 0);
      rready_m[1] = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) gap[k] = ($urandom_range(0, 4) == 0);
      tick();
      n0++;
    end
    chk("rnd_done", n0 < 4000, 1);
    rready_m[0] = 1'b1;
    rready_m[1] = 1'b1;
    for (int k = 0; k < 3; k++) gap[k] = 1'b0;
    tick();
    chk("rnd_m0_beats", rcv[0], e0);
    chk("rnd_m1_beats", rcv[1], e1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
